// File: rtl/switch_debounce.sv
// Multi-bit switch debouncer: two-flop synchronizer per input, one shared sample-tick
// prescaler, and a per-bit saturating agreement counter that accepts a new level only
// after it has been seen on STABLE_TICKS consecutive ticks. Edge pulses are registered
// alongside the debounced level.
module switch_debounce #(
  parameter int WIDTH        = 14,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  // Minimum width of 1 keeps the degenerate parameter values legal.
  localparam int PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CntW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]            s1_q, s2_q;
  logic [PreW-1:0]             presc_q, presc_d;
  logic                        tick;
  logic [WIDTH-1:0][CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]            db_q, db_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;

  // Two-flop synchronizer; only s2 feeds the debounce logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw_raw;
      s2_q <= s1_q;
    end
  end

  // Shared prescaler: tick on the last count, then wrap. With TICK_DIV == 1 it stays at 0
  // and ticks every cycle.
  always_comb begin
    tick    = (presc_q == PreMax);
    presc_d = tick ? '0 : presc_q + PreW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Per-bit debounce: agreement clears the count; a disagreeing tick advances it, and the
  // final disagreeing tick commits the new level and fires exactly one edge pulse.
  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CntMax) begin
          cnt_d[i]  = '0;
          db_d[i]   = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Debounce state and registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Outputs straight from registers; any_change is a reduction of the registered pulses.
  always_comb begin
    sw_db      = db_q;
    sw_rise    = rise_q;
    sw_fall    = fall_q;
    any_change = |(rise_q | fall_q);
  end

endmodule
